lpif_master_link_sync: RTL

- Master-end link-bring-up sequencer for the x8 asym2 half-rate LPIF link, the counterpart to the slave-side auto-sync.
- It qualifies the raw tx_online/rx_online controls with programmable delays.
- It generates the marker and strobe userbits the far end uses for word alignment.
- Its outputs feed the master concat block's tx_online, tx_mrk_userbit and tx_stb_userbit inputs, and the master debug status.

---
 rtl/lpif_master_link_sync.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lpif_master_link_sync.sv
// lpif_master_link_sync
// Master-end bring-up sequencer for the x8 asym2 half-rate LPIF link.
// Qualifies tx_online / rx_online with programmable delays and generates the
// marker and strobe userbits the far end aligns on.
//
// Handshake-free block: every input is sampled on each rising clk_wr edge and
// every output is a register, so the far-end concat block sees glitch-free
// levels. The debug bus sync_state exposes both FSM encodings directly.
//
// Timing summary (k = edge at which tx_online is first sampled high):
//   edge k          : TX IDLE -> WAIT_X, txcnt <= delay_x_value
//   edges k+1..k+N  : txcnt counts down to 0
//   edge k+N+1      : TX WAIT_X -> ON
//   edge k+N+2      : tx_online_delay registers high
// The RX path mirrors this with WAIT_Y / HOLD / ON, and its output register is
// additionally gated by the live rx_online, rx_online_holdoff and tx_online
// levels so that a drop or holdoff clears rx_online_delay on the very next
// edge rather than one edge later.

module lpif_master_link_sync #(
    parameter int unsigned MARKER_WIDTH      = 2,
    parameter bit          PERSISTENT_MARKER = 1'b1,
    parameter bit          PERSISTENT_STROBE = 1'b1,
    parameter logic [15:0] MARKER_PERIOD     = 16'd8,
    parameter logic [15:0] STROBE_PERIOD     = 16'd8
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr,
    input  logic                    tx_online,
    input  logic                    rx_online,
    input  logic                    rx_online_holdoff,
    input  logic [15:0]             delay_x_value,
    input  logic [15:0]             delay_y_value,
    input  logic [15:0]             delay_z_value,
    input  logic [MARKER_WIDTH-1:0] tx_mrk_userbit,
    input  logic                    tx_stb_userbit,
    output logic                    tx_online_delay,
    output logic                    rx_online_delay,
    output logic [MARKER_WIDTH-1:0] tx_auto_mrk_userbit,
    output logic                    tx_auto_stb_userbit,
    output logic [3:0]              sync_state
);

    // Last count value of each free-running period counter.
    localparam logic [15:0] MRK_LAST = MARKER_PERIOD - 16'd1;
    localparam logic [15:0] STB_LAST = STROBE_PERIOD - 16'd1;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_WAIT_X = 2'd1,
        TX_ON     = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_WAIT_Y = 2'd1,
        RX_HOLD   = 2'd2,
        RX_ON     = 2'd3
    } rx_state_e;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    tx_state_e tx_state_q, tx_state_d;
    rx_state_e rx_state_q, rx_state_d;

    logic [15:0] txcnt_q, txcnt_d;
    logic [15:0] rxcnt_q, rxcnt_d;
    logic [15:0] mcnt_q,  mcnt_d;
    logic [15:0] scnt_q,  scnt_d;
    logic [15:0] zcnt_q,  zcnt_d;
    logic        z_armed_q, z_armed_d;

    logic                    tx_delay_q, tx_delay_d;
    logic                    rx_delay_q, rx_delay_d;
    logic [MARKER_WIDTH-1:0] mrk_q,      mrk_d;
    logic                    stb_q,      stb_d;

    // Derived qualifiers shared by several processes.
    logic tx_up;         // TX qualified and request still present
    logic tx_run;        // TX past IDLE and request still present
    logic wait_x_entry;  // this edge moves TX from IDLE into WAIT_X
    logic z_load;        // first rising edge of rx_online_delay in this link-up
    logic stb_stop;      // non-persistent strobe tail has expired

    // Shared qualifiers derived from the current state and live inputs.
    always_comb begin
        tx_up        = (tx_state_q == TX_ON) && tx_online;
        tx_run       = (tx_state_q != TX_IDLE) && tx_online;
        wait_x_entry = (tx_state_q == TX_IDLE) && (tx_state_d == TX_WAIT_X);
        z_load       = rx_delay_d && !rx_delay_q && !z_armed_q;
        stb_stop     = !PERSISTENT_STROBE && z_armed_q && (zcnt_q == 16'd0);
    end

    // TX FSM next-state: IDLE -> WAIT_X (count delay_x) -> ON; drop returns to IDLE.
    always_comb begin
        tx_state_d = tx_state_q;
        txcnt_d    = txcnt_q;
        if (!tx_online) begin
            tx_state_d = TX_IDLE;
            txcnt_d    = 16'd0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_state_d = TX_WAIT_X;
                    txcnt_d    = delay_x_value;
                end
                TX_WAIT_X: begin
                    if (txcnt_q == 16'd0) begin
                        tx_state_d = TX_ON;
                    end else begin
                        txcnt_d = txcnt_q - 16'd1;
                    end
                end
                TX_ON: begin
                    tx_state_d = TX_ON;
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    txcnt_d    = 16'd0;
                end
            endcase
        end
    end

    // RX FSM next-state: IDLE -> WAIT_Y (count delay_y) -> HOLD -> ON, with holdoff bouncing ON <-> HOLD.
    always_comb begin
        rx_state_d = rx_state_q;
        rxcnt_d    = rxcnt_q;
        if (!rx_online || !tx_up) begin
            rx_state_d = RX_IDLE;
            rxcnt_d    = 16'd0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_state_d = RX_WAIT_Y;
                    rxcnt_d    = delay_y_value;
                end
                RX_WAIT_Y: begin
                    if (rxcnt_q == 16'd0) begin
                        rx_state_d = RX_HOLD;
                    end else begin
                        rxcnt_d = rxcnt_q - 16'd1;
                    end
                end
                RX_HOLD: begin
                    if (!rx_online_holdoff) begin
                        rx_state_d = RX_ON;
                    end
                end
                RX_ON: begin
                    if (rx_online_holdoff) begin
                        rx_state_d = RX_HOLD;
                    end
                end
                default: begin
                    rx_state_d = RX_IDLE;
                    rxcnt_d    = 16'd0;
                end
            endcase
        end
    end

    // Qualified online outputs: asserted while the FSM sits in ON and the
    // live requests still hold, so a drop clears them on the next edge.
    always_comb begin
        tx_delay_d = tx_up;
        rx_delay_d = (rx_state_q == RX_ON) && rx_online && !rx_online_holdoff && tx_up;
    end

    // Marker period counter and marker output value.
    always_comb begin
        mcnt_d = 16'd0;
        mrk_d  = '0;
        if (wait_x_entry) begin
            mcnt_d = 16'd0;
        end else if (tx_run) begin
            mcnt_d = (mcnt_q == MRK_LAST) ? 16'd0 : mcnt_q + 16'd1;
        end
        if (tx_run) begin
            if (PERSISTENT_MARKER) begin
                mrk_d = tx_mrk_userbit;
            end else if (mcnt_q == MRK_LAST) begin
                mrk_d = tx_mrk_userbit;
            end
        end
    end

    // Strobe period counter, strobe tail counter and strobe output value.
    always_comb begin
        scnt_d    = 16'd0;
        zcnt_d    = zcnt_q;
        z_armed_d = z_armed_q;
        stb_d     = 1'b0;

        if (wait_x_entry) begin
            scnt_d = 16'd0;
        end else if (tx_run) begin
            scnt_d = (scnt_q == STB_LAST) ? 16'd0 : scnt_q + 16'd1;
        end

        // The tail counter is armed once per link-up and released only when
        // TX falls back to IDLE.
        if (tx_state_d == TX_IDLE) begin
            z_armed_d = 1'b0;
            zcnt_d    = 16'd0;
        end else if (z_load) begin
            z_armed_d = 1'b1;
            zcnt_d    = delay_z_value;
        end else if (z_armed_q && (zcnt_q != 16'd0)) begin
            zcnt_d = zcnt_q - 16'd1;
        end

        if (tx_run && !stb_stop && (scnt_q == STB_LAST)) begin
            stb_d = tx_stb_userbit;
        end
    end

    // FSM state registers and delay counters.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            txcnt_q    <= 16'd0;
            rxcnt_q    <= 16'd0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            txcnt_q    <= txcnt_d;
            rxcnt_q    <= rxcnt_d;
        end
    end

    // Userbit generator counters.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            mcnt_q    <= 16'd0;
            scnt_q    <= 16'd0;
            zcnt_q    <= 16'd0;
            z_armed_q <= 1'b0;
        end else begin
            mcnt_q    <= mcnt_d;
            scnt_q    <= scnt_d;
            zcnt_q    <= zcnt_d;
            z_armed_q <= z_armed_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            tx_delay_q <= 1'b0;
            rx_delay_q <= 1'b0;
            mrk_q      <= '0;
            stb_q      <= 1'b0;
        end else begin
            tx_delay_q <= tx_delay_d;
            rx_delay_q <= rx_delay_d;
            mrk_q      <= mrk_d;
            stb_q      <= stb_d;
        end
    end

    assign tx_online_delay     = tx_delay_q;
    assign rx_online_delay     = rx_delay_q;
    assign tx_auto_mrk_userbit = mrk_q;
    assign tx_auto_stb_userbit = stb_q;
    assign sync_state          = {rx_state_q, tx_state_q};

endmodule
